// File: rtl/recursive_doubling.sv
// One-cycle ALU: parallel-prefix (Kogge-Stone style) add/subtract and logarithmic
// barrel shifters, with a single registered output stage.
module recursive_doubling #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [7:0]       shamt,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             out_valid
);

  // Handshake: in_valid qualifies op/a/b/cin/shamt at a rising edge; there is no
  // ready, every valid input yields out_valid=1 with its result one edge later.

  localparam int LEVELS = $clog2(WIDTH);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SHL = 2'b10;
  localparam logic [1:0] OP_SHR = 2'b11;

  logic             sub_sel;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [LEVELS:0][WIDTH-1:0] gk;
  logic [LEVELS:0][WIDTH-1:0] pk;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign sub_sel = (op == OP_SUB);
  assign b_eff   = sub_sel ? ~b : b;
  assign c0      = sub_sel ? 1'b1 : cin;

  assign gk[0] = a & b_eff;
  assign pk[0] = a ^ b_eff;

  // Each level combines a bit's group with the group SPAN bits below it.
  for (genvar lv = 0; lv < LEVELS; lv++) begin : g_level
    localparam int SPAN = 1 << lv;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= SPAN) begin : g_comb
        assign gk[lv+1][i] = gk[lv][i] | (pk[lv][i] & gk[lv][i-SPAN]);
        assign pk[lv+1][i] = pk[lv][i] & pk[lv][i-SPAN];
      end else begin : g_pass
        assign gk[lv+1][i] = gk[lv][i];
        assign pk[lv+1][i] = pk[lv][i];
      end
    end
  end

  // Carry-in folds in through the full-span group propagate of bits [i:0].
  assign carry[0]       = c0;
  assign carry[WIDTH:1] = gk[LEVELS] | (pk[LEVELS] & {WIDTH{c0}});
  assign sum            = pk[0] ^ carry[WIDTH-1:0];

  logic [LEVELS:0][WIDTH-1:0] shl;
  logic [LEVELS:0][WIDTH-1:0] shr;
  logic                       sh_zero;

  assign shl[0]  = a;
  assign shr[0]  = a;
  assign sh_zero = |shamt[7:LEVELS];

  for (genvar s = 0; s < LEVELS; s++) begin : g_shift
    localparam int SPAN = 1 << s;
    assign shl[s+1] = shamt[s] ? (shl[s] << SPAN) : shl[s];
    assign shr[s+1] = shamt[s] ? (shr[s] >> SPAN) : shr[s];
  end

  logic [WIDTH-1:0] result_d, result_q;
  logic             cout_d, cout_q;
  logic             out_valid_d, out_valid_q;

  always_comb begin
    result_d    = result_q;
    cout_d      = cout_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      out_valid_d = 1'b1;
      case (op)
        OP_ADD, OP_SUB: begin
          result_d = sum;
          cout_d   = carry[WIDTH];
        end
        OP_SHL: begin
          result_d = sh_zero ? '0 : shl[LEVELS];
          cout_d   = 1'b0;
        end
        default: begin
          result_d = sh_zero ? '0 : shr[LEVELS];
          cout_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q    <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_recursive_doubling.sv
// Directed and random checks of the one-cycle add/sub/shift unit against a
// behavioural model, with a queue of expected {cout,result} words.
module tb_recursive_doubling;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [7:0]  shamt;
  logic [31:0] result;
  logic        cout;
  logic        out_valid;

  int total;
  int bad;

  logic [32:0] exp_q[$];
  logic [32:0] held;

  recursive_doubling #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .shamt     (shamt),
    .result    (result),
    .cout      (cout),
    .out_valid (out_valid)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [32:0] model(input logic [1:0] o, input logic [31:0] av,
                                        input logic [31:0] bv, input logic ci,
                                        input logic [7:0] sa);
    logic [32:0] r;
    case (o)
      2'b00:   r = {1'b0, av} + {1'b0, bv} + 33'(ci);
      2'b01:   r = {1'b0, av} + {1'b0, ~bv} + 33'd1;
      2'b10:   r = (sa >= 8'd32) ? 33'd0 : {1'b0, av << sa};
      default: r = (sa >= 8'd32) ? 33'd0 : {1'b0, av >> sa};
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance one edge and compare whatever the DUT should present after it.
  task automatic cycle(input string tag);
    logic [32:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, {32'd0, out_valid}, 33'd1);
      check(tag, {cout, result}, e);
      held = e;
    end else begin
      check({tag, "_idle_valid"}, {32'd0, out_valid}, 33'd0);
      check({tag, "_held"}, {cout, result}, held);
    end
  endtask

  // driver: present one valid op and push its expected output
  task automatic drive(input string tag, input logic [1:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input logic ci, input logic [7:0] sa);
    in_valid = 1'b1;
    op       = o;
    a        = av;
    b        = bv;
    cin      = ci;
    shamt    = sa;
    exp_q.push_back(model(o, av, bv, ci, sa));
    cycle(tag);
  endtask

  task automatic idle(input string tag);
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    cycle(tag);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    held     = 33'd0;
    rst      = 1'b1;
    in_valid = 1'b0;
    op       = 2'b00;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    shamt    = '0;

    #1;
    check("reset_out", {cout, result}, 33'd0);
    check("reset_valid", {32'd0, out_valid}, 33'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_valid", {32'd0, out_valid}, 33'd0);

    // directed vectors
    drive("add_82_7e", 2'b00, 32'h82, 32'h7E, 1'b0, 8'd0);
    check("add_82_7e_const", {cout, result}, {1'b0, 32'h0000_0100});
    drive("sub_100_7f", 2'b01, 32'h100, 32'h7F, 1'b0, 8'd0);
    check("sub_100_7f_const", {cout, result}, {1'b1, 32'h0000_0081});
    drive("sub_7f_80", 2'b01, 32'h7F, 32'h80, 1'b1, 8'd0);
    check("sub_7f_80_const", {cout, result}, {1'b0, 32'hFFFF_FFFF});
    drive("add_full_carry", 2'b00, 32'hFFFF_FFFF, 32'h0, 1'b1, 8'd0);
    check("add_full_carry_const", {cout, result}, {1'b1, 32'h0000_0000});
    drive("shr_4", 2'b11, 32'hF000_0000, 32'h1234, 1'b1, 8'd4);
    check("shr_4_const", {cout, result}, {1'b0, 32'h0F00_0000});
    drive("shl_31", 2'b10, 32'h0000_0001, 32'h0, 1'b0, 8'd31);
    check("shl_31_const", {cout, result}, {1'b0, 32'h8000_0000});
    drive("shl_81", 2'b10, 32'hFFFF_FFFF, 32'h0, 1'b0, 8'h81);
    drive("shr_32", 2'b11, 32'hFFFF_FFFF, 32'h0, 1'b0, 8'd32);
    drive("shl_0", 2'b10, 32'hA5A5_5A5A, 32'h0, 1'b1, 8'd0);
    drive("shr_31", 2'b11, 32'h8000_0000, 32'h0, 1'b0, 8'd31);
    drive("sub_eq", 2'b01, 32'h1234_5678, 32'h1234_5678, 1'b0, 8'd0);
    drive("add_alt", 2'b00, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 8'd0);

    // back-to-back stream then idle: held result, out_valid low
    drive("b2b_0", 2'b00, 32'h1, 32'h2, 1'b0, 8'd0);
    drive("b2b_1", 2'b01, 32'h10, 32'h3, 1'b0, 8'd0);
    drive("b2b_2", 2'b10, 32'h3, 32'h0, 1'b0, 8'd5);
    idle("b2b_idle0");
    idle("b2b_idle1");

    // random back-to-back traffic, occasionally idle
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) idle("rnd_idle");
      else drive("rnd", 2'($urandom_range(0, 3)), $urandom, $urandom,
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 40)));
    end

    // reset between edges while a valid op is pending
    drive("pre_rst", 2'b00, 32'h0000_FFFF, 32'h1, 1'b0, 8'd0);
    in_valid = 1'b1;
    op       = 2'b00;
    a        = 32'hDEAD_BEEF;
    b        = 32'h1111_1111;
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_out", {cout, result}, 33'd0);
    check("mid_rst_valid", {32'd0, out_valid}, 33'd0);
    @(posedge clk);
    #1;
    check("rst_edge_out", {cout, result}, 33'd0);
    check("rst_edge_valid", {32'd0, out_valid}, 33'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    held     = 33'd0;
    exp_q.delete();
    cycle("after_rst_idle");
    drive("after_rst_add", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 8'd0);
    drive("after_rst_shr", 2'b11, 32'h8000_0001, 32'h0, 1'b0, 8'd1);
    idle("final_idle");

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
